// File: rtl/config_loader_pkg.sv
// rtl/config_loader_pkg.sv - shared types and helpers for the configuration bitstream loader
//
// Purpose: loader FSM state encoding and the counter-width helper used by the
// loader top and its readback deserializer.
// Ports: none (package).

package config_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_t;

    // Width of a counter that must hold every value from 0 up to max_value.
    function automatic int count_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/config_readback_deserializer.sv
// rtl/config_readback_deserializer.sv - packs bits leaving the config chain tail into words
//
// Purpose: collects one bit per enabled cycle LSB-first and emits a word with a
// one-cycle valid pulse after WORD_WIDTH samples. A flush emits any partial
// word zero-padded (the flush cycle's own sample is included).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   sample_en          capture sample_bit at this edge
//   sample_bit         bit leaving the chain tail
//   flush              end of load; emit a partial word if one is pending
//   word_data          assembled word, first captured bit in bit 0
//   word_valid         one-cycle pulse per emitted word

module config_readback_deserializer
    import config_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_en,
    input  logic                  sample_bit,
    input  logic                  flush,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic                  word_valid
);

    localparam int              IW       = count_width(WORD_WIDTH - 1);
    localparam logic [IW-1:0]   LAST_IDX = IW'(WORD_WIDTH - 1);

    logic [WORD_WIDTH-1:0] acc;
    logic [WORD_WIDTH-1:0] acc_next;
    logic [IW-1:0]         idx;
    logic                  emit;

    always_comb begin
        acc_next = acc;
        if (sample_en) begin
            acc_next[idx] = sample_bit;
        end
    end

    // A flush with nothing captured (and no sample this cycle) emits nothing.
    assign emit = (sample_en && (idx == LAST_IDX)) || (flush && (sample_en || (idx != '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            idx        <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
        end else if (emit) begin
            // acc restarts from zero so a later partial word is already padded.
            word_data  <= acc_next;
            word_valid <= 1'b1;
            acc        <= '0;
            idx        <= '0;
        end else begin
            word_valid <= 1'b0;
            acc        <= acc_next;
            if (sample_en) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/config_bitstream_loader.sv
// rtl/config_bitstream_loader.sv - serialises a configuration bitstream into the tile config chain
//
// Purpose: accepts bitstream words over valid/ready, shifts them LSB-first into
// the first tile's config register for exactly CHAIN_LENGTH enabled cycles, and
// returns the bits leaving the chain tail as readback words.
// Ports:
//   config_clock, config_nreset   clock, asynchronous active-low reset
//   start                         begin a load (IDLE or DONE only)
//   word_data/word_valid/word_ready  bitstream word handshake
//   chain_data_out, chain_enable  to first tile config_in / all tiles config_enable
//   chain_data_in                 from last tile config_out
//   busy, done                    LOAD / DONE state flags
//   readback_data, readback_valid captured tail words, one-cycle pulse each

module config_bitstream_loader
    import config_loader_pkg::*;
#(
    parameter int CHAIN_LENGTH = 12,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                  config_clock,
    input  logic                  config_nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  chain_data_out,
    output logic                  chain_enable,
    input  logic                  chain_data_in,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] readback_data,
    output logic                  readback_valid
);

    localparam int              CW        = count_width(CHAIN_LENGTH);
    localparam int              BW        = count_width(WORD_WIDTH);
    localparam int              XW        = (CW > BW) ? CW : BW;
    localparam logic [CW-1:0]   CHAIN_LEN = CW'(CHAIN_LENGTH);
    localparam logic [CW-1:0]   LAST_BIT  = CW'(CHAIN_LENGTH - 1);
    localparam logic [BW-1:0]   FULL_WORD = BW'(WORD_WIDTH);
    localparam logic [BW-1:0]   ONE_BIT   = BW'(1);

    loader_state_t         state;
    logic [CW-1:0]         bit_count;
    // Bits of the current word not yet shifted, including the one on chain_data_out.
    logic [BW-1:0]         bits_left;
    logic [WORD_WIDTH-1:0] sr;
    logic [CW-1:0]         remaining;
    logic                  handshake;
    logic                  final_bit;

    assign remaining = CHAIN_LEN - bit_count;

    // A new word can be taken when nothing is held, or when the last held bit
    // leaves at this edge, so back-to-back words shift without a gap.
    assign word_ready = (state == ST_LOAD)
                     && ((bits_left == '0) || ((bits_left == ONE_BIT) && chain_enable))
                     && (XW'(remaining) > XW'(bits_left));

    assign handshake = word_valid && word_ready;
    assign final_bit = (state == ST_LOAD) && chain_enable && (bit_count == LAST_BIT);
    assign busy      = (state == ST_LOAD);
    assign done      = (state == ST_DONE);

    always_ff @(posedge config_clock or negedge config_nreset) begin
        if (!config_nreset) begin
            state          <= ST_IDLE;
            bit_count      <= '0;
            bits_left      <= '0;
            sr             <= '0;
            chain_data_out <= 1'b0;
            chain_enable   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        bit_count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (chain_enable) begin
                        bit_count <= bit_count + 1'b1;
                    end
                    if (final_bit) begin
                        // Any surplus bits of the final word are dropped here.
                        state        <= ST_DONE;
                        chain_enable <= 1'b0;
                        bits_left    <= '0;
                    end else if (handshake) begin
                        chain_data_out <= word_data[0];
                        sr             <= word_data >> 1;
                        chain_enable   <= 1'b1;
                        bits_left      <= FULL_WORD;
                    end else if (chain_enable && (bits_left > ONE_BIT)) begin
                        chain_data_out <= sr[0];
                        sr             <= sr >> 1;
                        bits_left      <= bits_left - 1'b1;
                    end else if (chain_enable) begin
                        // Word exhausted with no successor: stall, data holds.
                        chain_enable <= 1'b0;
                        bits_left    <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    config_readback_deserializer #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_readback (
        .clk        (config_clock),
        .rst_n      (config_nreset),
        .sample_en  (chain_enable),
        .sample_bit (chain_data_in),
        .flush      (final_bit),
        .word_data  (readback_data),
        .word_valid (readback_valid)
    );

endmodule

// File: tb/tb_config_bitstream_loader.sv
// tb/tb_config_bitstream_loader.sv - self-checking bench for config_bitstream_loader

module tb_config_bitstream_loader;

    localparam int L      = 12;
    localparam int W      = 8;
    localparam int NW_MAX = 4;
    localparam int NRB    = (L + W - 1) / W;

    logic         config_clock = 1'b0;
    logic         config_nreset;
    logic         start;
    logic [W-1:0] word_data;
    logic         word_valid;
    logic         word_ready;
    logic         chain_data_out;
    logic         chain_enable;
    logic         chain_data_in;
    logic         busy;
    logic         done;
    logic [W-1:0] readback_data;
    logic         readback_valid;

    config_bitstream_loader #(.CHAIN_LENGTH(L), .WORD_WIDTH(W)) dut (
        .config_clock   (config_clock),
        .config_nreset  (config_nreset),
        .start          (start),
        .word_data      (word_data),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .chain_data_out (chain_data_out),
        .chain_enable   (chain_enable),
        .chain_data_in  (chain_data_in),
        .busy           (busy),
        .done           (done),
        .readback_data  (readback_data),
        .readback_valid (readback_valid)
    );

    always #5 config_clock = ~config_clock;

    // Three 4-bit IO tiles as one shift chain: tile[0] is the first tile's
    // input end, tile[L-1] the tail. Not reset by config_nreset.
    logic [L-1:0] tile;
    logic [L-1:0] preload_val;
    logic         preload_req = 1'b0;
    assign chain_data_in = tile[L-1];
    always @(posedge config_clock) begin
        if (preload_req) tile <= preload_val;
        else if (chain_enable) tile <= {tile[L-2:0], chain_data_out};
    end

    int           tests_run = 0;
    int           tests_failed = 0;
    logic [W-1:0] words [NW_MAX];
    bit           q_bits[$];
    bit           q_en[$];
    logic [W-1:0] q_rb[$];
    bit           q_rb_rise[$];
    int           hs_count;
    bit           ready_when_full;
    bit           load_finished;
    logic [L-1:0] chain_before;

    // Reference model: stream bit i is bit (i mod W) of word (i div W).
    function automatic bit exp_bit(input int i);
        logic [W-1:0] w;
        w = words[i / W];
        return w[i % W];
    endfunction

    // Readback word k holds chain bits k*W.. in order of leaving the tail.
    function automatic logic [W-1:0] exp_rb(input int k);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < W; j++)
            if (k * W + j < L) r[j] = chain_before[L-1-(k*W+j)];
        return r;
    endfunction

    function automatic int bit_errors();
        int e;
        e = (q_bits.size() == L) ? 0 : 1;
        for (int i = 0; i < q_bits.size() && i < L; i++)
            if (q_bits[i] !== exp_bit(i)) e++;
        return e;
    endfunction

    function automatic int tile_errors();
        int e;
        e = 0;
        for (int i = 0; i < L; i++)
            if (tile[L-1-i] !== exp_bit(i)) e++;
        return e;
    endfunction

    function automatic int rb_errors();
        int e;
        e = (q_rb.size() == NRB) ? 0 : 1;
        for (int k = 0; k < q_rb.size() && k < NRB; k++) begin
            if (q_rb[k] !== exp_rb(k)) e++;
            if (q_rb_rise[k] != (k == NRB - 1)) e++;
        end
        return e;
    endfunction

    function automatic int en_ones();
        int n;
        n = 0;
        foreach (q_en[i]) if (q_en[i]) n++;
        return n;
    endfunction

    function automatic int en_gaps();
        int first, last, n;
        first = -1; last = -1; n = 0;
        foreach (q_en[i]) if (q_en[i]) begin if (first < 0) first = i; last = i; end
        for (int i = first + 1; i < last; i++) if (!q_en[i]) n++;
        return n;
    endfunction

    function automatic logic [L-1:0] packed_bits();
        logic [L-1:0] p;
        p = '0;
        for (int i = 0; i < q_bits.size() && i < L; i++) p[i] = q_bits[i];
        return p;
    endfunction

    task automatic preload_chain(input logic [L-1:0] first_out);
        for (int i = 0; i < L; i++) preload_val[L-1-i] = first_out[i];
        preload_req = 1'b1;
        @(posedge config_clock); #1;
        preload_req = 1'b0;
    endtask

    // Drives one load and logs per-cycle observations sampled at the falling edge.
    task automatic run_load(input int n_words, input bit do_start, input int stall_n,
                            input bit rand_valid, input int start_mid_at, input int abort_at);
        int idx;
        int stall_left;
        bit hs;
        bit prev_done;
        bit mid_done;
        idx = 0; stall_left = stall_n; mid_done = 0;
        q_bits.delete(); q_en.delete(); q_rb.delete(); q_rb_rise.delete();
        hs_count = 0; ready_when_full = 0; load_finished = 0;
        chain_before = tile;
        prev_done = done;
        if (do_start) start = 1'b1;
        @(posedge config_clock); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            word_valid = (idx < n_words) && !(idx == 1 && stall_left > 0)
                      && (!rand_valid || $urandom_range(0, 3) != 0);
            word_data  = (idx < n_words) ? words[idx] : W'($urandom);
            if (start_mid_at >= 0 && !mid_done && q_bits.size() == start_mid_at) begin
                start = 1'b1; mid_done = 1;
            end
            @(negedge config_clock);
            if (chain_enable) q_bits.push_back(chain_data_out);
            q_en.push_back(chain_enable);
            if (readback_valid) begin
                q_rb.push_back(readback_data);
                q_rb_rise.push_back(done && !prev_done);
            end
            if (word_ready && hs_count * W >= L) ready_when_full = 1;
            if (idx == 1 && stall_left > 0 && word_ready) stall_left--;
            hs = word_valid && word_ready;
            prev_done = done;
            if (done) begin
                load_finished = 1; word_valid = 1'b0; start = 1'b0;
                return;
            end
            if (abort_at >= 0 && q_bits.size() == abort_at) begin
                word_valid = 1'b0; start = 1'b0;
                return;
            end
            @(posedge config_clock); #1;
            start = 1'b0;
            if (hs) begin idx++; hs_count++; end
        end
    endtask

    task automatic test_reset();
        config_nreset = 1'b0; start = 1'b0; word_valid = 1'b0; word_data = '0;
        preload_chain(L'($urandom));
        @(posedge config_clock); #1;
        tests_run++;
        if ({chain_enable, chain_data_out, word_ready, busy, done, readback_valid, readback_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got en=%b do=%b rdy=%b busy=%b done=%b rbv=%b rbd=%h want all 0",
                     chain_enable, chain_data_out, word_ready, busy, done, readback_valid, readback_data);
        end
        config_nreset = 1'b1;
        word_valid = 1'b1;
        @(negedge config_clock);
        tests_run++;
        if ({chain_enable, word_ready, busy, done} !== 4'b0) begin
            tests_failed++;
            $display("FAIL idle_ignores_valid: got en=%b rdy=%b busy=%b done=%b want 0000",
                     chain_enable, word_ready, busy, done);
        end
        word_valid = 1'b0;
    endtask

    task automatic test_load_order();
        words[0] = 8'hA5; words[1] = 8'h3C;
        run_load(2, 1, 0, 0, -1, -1);
        tests_run++;
        if (!load_finished) begin tests_failed++; $display("FAIL load_order_timeout: done never rose"); end
        tests_run++;
        if (en_ones() != L || en_gaps() != 0) begin
            tests_failed++;
            $display("FAIL load_order_enable: got %0d enabled cycles %0d gaps want %0d and 0", en_ones(), en_gaps(), L);
        end
        tests_run++;
        if (packed_bits() !== 12'hCA5 || bit_errors() != 0) begin
            tests_failed++;
            $display("FAIL load_order_bits: got %h (%0d bits) want ca5", packed_bits(), q_bits.size());
        end
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL load_order_flags: got done=%b busy=%b want 1 0", done, busy);
        end
        #2;
        tests_run++;
        if (tile_errors() != 0 || tile[L-1] !== 1'b1) begin
            tests_failed++; $display("FAIL load_order_tiles: got chain %b, %0d bit errors", tile, tile_errors());
        end
        word_valid = 1'b1;
        @(negedge config_clock);
        tests_run++;
        if (word_ready !== 1'b0) begin
            tests_failed++; $display("FAIL done_ignores_valid: got word_ready=%b want 0", word_ready);
        end
        word_valid = 1'b0;
    endtask

    task automatic test_stall();
        words[0] = 8'hA5; words[1] = 8'h3C;
        run_load(2, 1, 3, 0, -1, -1);
        tests_run++;
        if (!load_finished || en_ones() != L || en_gaps() != 3) begin
            tests_failed++;
            $display("FAIL stall_enable: got done=%b %0d enabled %0d gap cycles want 1 %0d 3", load_finished, en_ones(), en_gaps(), L);
        end
        tests_run++;
        if (packed_bits() !== 12'hCA5 || bit_errors() != 0) begin
            tests_failed++; $display("FAIL stall_bits: got %h want ca5", packed_bits());
        end
    endtask

    task automatic test_readback();
        preload_chain(12'hABC);
        words[0] = W'($urandom); words[1] = W'($urandom);
        run_load(2, 1, 0, 0, -1, -1);
        tests_run++;
        if (q_rb.size() != 2 || q_rb[0] !== 8'hBC || q_rb[1] !== 8'h0A) begin
            tests_failed++;
            $display("FAIL readback_words: got %0d words first %h last %h want 2 words bc 0a",
                     q_rb.size(), (q_rb.size() > 0) ? q_rb[0] : 8'h00, (q_rb.size() > 1) ? q_rb[1] : 8'h00);
        end
        tests_run++;
        if (q_rb.size() != 2 || q_rb_rise[0] || !q_rb_rise[1]) begin
            tests_failed++; $display("FAIL readback_with_done: second pulse not coincident with done rising");
        end
        tests_run++;
        if (bit_errors() != 0) begin tests_failed++; $display("FAIL readback_load_bits: got %h", packed_bits()); end
    endtask

    task automatic test_reload();
        words[0] = 8'hA5; words[1] = 8'h3C;
        run_load(2, 1, 0, 0, 6, -1);
        tests_run++;
        if (!load_finished || en_ones() != L || packed_bits() !== 12'hCA5 || hs_count != 2) begin
            tests_failed++;
            $display("FAIL start_while_busy: got done=%b %0d enabled bits %h %0d words want 1 %0d ca5 2",
                     load_finished, en_ones(), packed_bits(), hs_count, L);
        end
        start = 1'b1;
        #1;
        tests_run++;
        if (done !== 1'b1) begin tests_failed++; $display("FAIL reload_done_before: got done=%b want 1", done); end
        @(posedge config_clock); #1;
        start = 1'b0;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL reload_done_drop: got done=%b busy=%b want 0 1", done, busy);
        end
        run_load(2, 0, 0, 0, -1, -1);
        tests_run++;
        if (!load_finished || en_ones() != L || bit_errors() != 0) begin
            tests_failed++; $display("FAIL reload_full: got done=%b %0d enabled bits %h", load_finished, en_ones(), packed_bits());
        end
    endtask

    task automatic test_reset_mid_load();
        words[0] = 8'hA5; words[1] = 8'h3C;
        run_load(2, 1, 0, 0, -1, 5);
        tests_run++;
        if (load_finished || q_bits.size() != 5 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL midload_progress: got %0d bits busy=%b want 5 1", q_bits.size(), busy);
        end
        config_nreset = 1'b0;
        #1;
        tests_run++;
        if ({chain_enable, chain_data_out, word_ready, busy, done, readback_valid, readback_data} !== '0) begin
            tests_failed++;
            $display("FAIL midload_async_reset: got en=%b do=%b rdy=%b busy=%b done=%b rbv=%b rbd=%h want all 0",
                     chain_enable, chain_data_out, word_ready, busy, done, readback_valid, readback_data);
        end
        start = 1'b1; word_valid = 1'b1;
        @(posedge config_clock); #1;
        config_nreset = 1'b1; start = 1'b0; word_valid = 1'b0;
        @(negedge config_clock);
        tests_run++;
        if ({chain_enable, word_ready, busy, done} !== 4'b0) begin
            tests_failed++; $display("FAIL midload_idle_after: got en=%b rdy=%b busy=%b done=%b want 0000",
                                     chain_enable, word_ready, busy, done);
        end
        run_load(2, 1, 0, 0, -1, -1);
        tests_run++;
        if (!load_finished || en_ones() != L || packed_bits() !== 12'hCA5) begin
            tests_failed++; $display("FAIL midload_fresh_load: got done=%b %0d enabled bits %h want 1 %0d ca5",
                                     load_finished, en_ones(), packed_bits(), L);
        end
    endtask

    task automatic test_surplus();
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
        run_load(3, 1, 0, 0, -1, -1);
        tests_run++;
        if (hs_count != 2 || ready_when_full) begin
            tests_failed++; $display("FAIL surplus_ready: got %0d words accepted ready_late=%b want 2 0", hs_count, ready_when_full);
        end
        tests_run++;
        if (q_bits.size() != L || packed_bits() !== 12'hCA5) begin
            tests_failed++; $display("FAIL surplus_bits: got %0d bits %h want %0d ca5", q_bits.size(), packed_bits(), L);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < NW_MAX; k++) words[k] = W'($urandom);
            preload_chain(L'($urandom));
            run_load(3, 1, 0, 1, -1, -1);
            #2;
            tests_run++;
            if (!load_finished || en_ones() != L || bit_errors() != 0 || tile_errors() != 0) begin
                tests_failed++;
                $display("FAIL random_load[%0d]: got done=%b %0d enabled bits %h chain errors %0d",
                         it, load_finished, en_ones(), packed_bits(), tile_errors());
            end
            tests_run++;
            if (rb_errors() != 0 || ready_when_full || hs_count != NRB) begin
                tests_failed++;
                $display("FAIL random_readback[%0d]: got %0d words, %0d errors, ready_late=%b, %0d accepted",
                         it, q_rb.size(), rb_errors(), ready_when_full, hs_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_order();
        test_stall();
        test_readback();
        test_reload();
        test_reset_mid_load();
        test_surplus();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
